// File: rtl/reg_file_wb.sv
// Register file with write-back scoreboard: 32 x DATA_WIDTH regs (r0 = 0) plus per-register pending bits.
// Latency: reads and busy flags are combinational; writes and marks land on the next rising clk edge.
// Backpressure: none, every strobe is accepted each cycle. Optional write-through bypass: REGFILE_BYPASS_EN.
module reg_file_wb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            rd_addr1,
    input  logic [4:0]            rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  busy1,
    output logic                  busy2,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  mark_en,
    input  logic [4:0]            mark_addr,
    output logic [5:0]            pending_count
);

    logic [DATA_WIDTH-1:0] regs [32];
    logic [31:0]           pending;

    logic wr_act;
    logic mark_act;

    assign wr_act   = wr_en   && (wr_addr   != 5'd0);
    assign mark_act = mark_en && (mark_addr != 5'd0);

    // Data storage: clear on reset, otherwise capture write-back data (r0 is never written).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_act) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard: write-back clears, issue sets; the mark is ordered last so a same-address
    // issue leaves the register pending for its new producer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (wr_act) begin
                pending[wr_addr] <= 1'b0;
            end
            if (mark_act) begin
                pending[mark_addr] <= 1'b1;
            end
        end
    end

    // Count is a popcount of the live pending bits, so it cannot drift from them.
    always_comb begin
        pending_count = 6'd0;
        for (int i = 1; i < 32; i++) begin
            pending_count = pending_count + 6'(pending[i]);
        end
    end

    // Read port 1: stored value and pending flag, r0 forced to zero/not busy.
    always_comb begin
        rd_data1 = (rd_addr1 == 5'd0) ? '0 : regs[rd_addr1];
        busy1    = (rd_addr1 == 5'd0) ? 1'b0 : pending[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_act && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
            busy1    = mark_act && (mark_addr == wr_addr);
        end
`endif
    end

    // Read port 2: same as port 1.
    always_comb begin
        rd_data2 = (rd_addr2 == 5'd0) ? '0 : regs[rd_addr2];
        busy2    = (rd_addr2 == 5'd0) ? 1'b0 : pending[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_act && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
            busy2    = mark_act && (mark_addr == wr_addr);
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: reset, r0, mark/write, same-cycle collision, count, bypass.
// Inputs change 1ns after the rising edge; outputs are checked 1ns after the edge or mid-cycle.
// No DUT handshakes, so every scenario runs a fixed number of cycles.
module tb_reg_file_wb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        busy1;
    logic        busy2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mark_en;
    logic [4:0]  mark_addr;
    logic [5:0]  pending_count;

    int checks;
    int failures;

    reg_file_wb #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .rd_data1      (rd_data1),
        .rd_data2      (rd_data2),
        .busy1         (busy1),
        .busy2         (busy2),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .mark_en       (mark_en),
        .mark_addr     (mark_addr),
        .pending_count (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        mark_en = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        idle();
    endtask

    task automatic do_mark(input logic [4:0] a);
        mark_en = 1'b1; mark_addr = a;
        step();
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_write(5'd5, 32'h5555_5555);
        do_mark(5'd6);
        do_mark(5'd7);
        // reset with strobes active must win
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFF;
        mark_en = 1'b1; mark_addr = 5'd10;
        step();
        step();
        rst_n = 1'b1;
        idle();
        rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        #1;
        checks++; if (rd_data1 !== 32'h0) begin failures++; $display("FAIL rst_r5 got=%h exp=%h", rd_data1, 32'h0); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL rst_busy_r6 got=%b exp=0", busy2); end
        checks++; if (pending_count !== 6'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", pending_count); end
        rd_addr1 = 5'd9; rd_addr2 = 5'd10;
        #1;
        checks++; if (rd_data1 !== 32'h0) begin failures++; $display("FAIL rst_wr_ignored got=%h exp=%h", rd_data1, 32'h0); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL rst_mark_ignored got=%b exp=0", busy2); end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
        mark_en = 1'b1; mark_addr = 5'd0;
        step();
        idle();
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        #1;
        checks++; if (rd_data1 !== 32'h0) begin failures++; $display("FAIL zero_data got=%h exp=%h", rd_data1, 32'h0); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy1); end
        checks++; if (pending_count !== 6'd0) begin failures++; $display("FAIL zero_count got=%0d exp=0", pending_count); end
    endtask

    task automatic test_mark_write();
        rd_addr1 = 5'd8;
        do_mark(5'd8);
        checks++; if (pending_count !== 6'd1) begin failures++; $display("FAIL mw_count_mark got=%0d exp=1", pending_count); end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL mw_busy_mark got=%b exp=1", busy1); end
        step(); step(); step();
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL mw_busy_hold got=%b exp=1", busy1); end
        do_write(5'd8, 32'h1234);
        checks++; if (rd_data1 !== 32'h1234) begin failures++; $display("FAIL mw_data got=%h exp=%h", rd_data1, 32'h1234); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL mw_busy_clr got=%b exp=0", busy1); end
        checks++; if (pending_count !== 6'd0) begin failures++; $display("FAIL mw_count_clr got=%0d exp=0", pending_count); end
    endtask

    task automatic test_same_cycle();
        rd_addr1 = 5'd17;
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'hA5A5_A5A5;
        mark_en = 1'b1; mark_addr = 5'd17;
        step();
        idle();
        checks++; if (rd_data1 !== 32'hA5A5_A5A5) begin failures++; $display("FAIL same_data got=%h exp=%h", rd_data1, 32'hA5A5_A5A5); end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL same_busy got=%b exp=1", busy1); end
        checks++; if (pending_count !== 6'd1) begin failures++; $display("FAIL same_count got=%0d exp=1", pending_count); end
        do_write(5'd17, 32'h1);
        checks++; if (rd_data1 !== 32'h1) begin failures++; $display("FAIL same_wr2_data got=%h exp=%h", rd_data1, 32'h1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL same_wr2_busy got=%b exp=0", busy1); end
        checks++; if (pending_count !== 6'd0) begin failures++; $display("FAIL same_wr2_count got=%0d exp=0", pending_count); end
    endtask

    task automatic test_count_sat();
        for (int i = 1; i < 32; i++) begin
            do_mark(5'(i));
        end
        checks++; if (pending_count !== 6'd31) begin failures++; $display("FAIL cnt_full got=%0d exp=31", pending_count); end
        do_mark(5'd5);
        checks++; if (pending_count !== 6'd31) begin failures++; $display("FAIL cnt_remark got=%0d exp=31", pending_count); end
        rd_addr1 = 5'd31;
        do_write(5'd31, 32'h31);
        checks++; if (pending_count !== 6'd30) begin failures++; $display("FAIL cnt_wr1 got=%0d exp=30", pending_count); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL cnt_wr1_busy got=%b exp=0", busy1); end
        do_write(5'd31, 32'h3131);
        checks++; if (pending_count !== 6'd30) begin failures++; $display("FAIL cnt_wr2 got=%0d exp=30", pending_count); end
        checks++; if (rd_data1 !== 32'h3131) begin failures++; $display("FAIL cnt_wr2_data got=%h exp=%h", rd_data1, 32'h3131); end
        // independent write r1 and mark r31 in one cycle: -1 +1
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h1;
        mark_en = 1'b1; mark_addr = 5'd31;
        step();
        idle();
        rd_addr2 = 5'd1;
        #1;
        checks++; if (pending_count !== 6'd30) begin failures++; $display("FAIL cnt_diff got=%0d exp=30", pending_count); end
        checks++; if ({busy1, busy2} !== 2'b10) begin failures++; $display("FAIL cnt_diff_busy got=%b exp=10", {busy1, busy2}); end
        do_reset();
        checks++; if (pending_count !== 6'd0) begin failures++; $display("FAIL cnt_reset got=%0d exp=0", pending_count); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
        do_write(5'd3, 32'h11);
        do_mark(5'd3);
        rd_addr2 = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'h77; exp_b = 1'b0;
`else
        exp_d = 32'h11; exp_b = 1'b1;
`endif
        checks++; if (rd_data2 !== exp_d) begin failures++; $display("FAIL byp_same_data got=%h exp=%h", rd_data2, exp_d); end
        checks++; if (busy2 !== exp_b) begin failures++; $display("FAIL byp_same_busy got=%b exp=%b", busy2, exp_b); end
        step();
        idle();
        checks++; if (rd_data2 !== 32'h77) begin failures++; $display("FAIL byp_next_data got=%h exp=%h", rd_data2, 32'h77); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL byp_next_busy got=%b exp=0", busy2); end
        // write and re-issue the same register: bypassed busy stays set
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h99;
        mark_en = 1'b1; mark_addr = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'h99; exp_b = 1'b1;
`else
        exp_d = 32'h77; exp_b = 1'b0;
`endif
        checks++; if (rd_data2 !== exp_d) begin failures++; $display("FAIL byp_mark_data got=%h exp=%h", rd_data2, exp_d); end
        checks++; if (busy2 !== exp_b) begin failures++; $display("FAIL byp_mark_busy got=%b exp=%b", busy2, exp_b); end
        step();
        idle();
        checks++; if (rd_data2 !== 32'h99) begin failures++; $display("FAIL byp_mark_next_data got=%h exp=%h", rd_data2, 32'h99); end
        checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL byp_mark_next_busy got=%b exp=1", busy2); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        mark_en = 1'b0; mark_addr = 5'd0;
        do_reset();
        test_reset();
        test_zero_reg();
        test_mark_write();
        test_same_cycle();
        test_count_sat();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Register file with write-back scoreboard; sits directly downstream of the 5-bit destination-register select mux (rt vs rd).
- The mux result drives wr_addr (write-back) and mark_addr (issue); this block stores the results and tracks which registers still await a write.
- 32 registers, register 0 hardwired to zero; two combinational read ports, one synchronous write port.

Parameters:
DATA_WIDTH, 32, width of each register and of the read/write data buses.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
rd_addr1  input  5  read port 1 address
rd_addr2  input  5  read port 2 address
rd_data1  output  DATA_WIDTH  read port 1 data
rd_data2  output  DATA_WIDTH  read port 2 data
busy1  output  1  register at rd_addr1 has a pending write
busy2  output  1  register at rd_addr2 has a pending write
wr_en  input  1  write-back strobe
wr_addr  input  5  write-back destination (from the dest-select mux)
wr_data  input  DATA_WIDTH  write-back data
mark_en  input  1  issue strobe: destination becomes pending
mark_addr  input  5  issued destination (from the dest-select mux)
pending_count  output  6  number of registers currently pending (0..31)

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. Reset is sampled only on a rising clk edge.
- Reset (rst_n=0 at an edge):
  - all 32 registers cleared to 0; all pending bits cleared.
  - consequently rd_data1/2=0, busy1/2=0, pending_count=0 after that edge.
  - reset overrides wr_en and mark_en in the same cycle.
- State: regs[0..31] (DATA_WIDTH each) and pending[0..31] (1 bit each). regs[0] and pending[0] are constant 0.
- Reads (combinational, zero latency):
  - rd_dataN = regs[rd_addrN]; busyN = pending[rd_addrN].
  - Address 0 always returns data 0 and busy 0.
- Write (edge, wr_en=1, wr_addr!=0):
  - regs[wr_addr] <= wr_data next edge.
  - pending[wr_addr] is cleared.
  - wr_addr=0 is ignored entirely.
- Mark (edge, mark_en=1, mark_addr!=0):
  - pending[mark_addr] is set.
  - Re-marking an already pending register leaves it set, with no count change.
  - mark_addr=0 is ignored.
- Simultaneous write and mark:
  - Different addresses: both take effect independently.
  - Same address: the data is written, pending ends set (the new producer wins), and pending_count reflects the final pending state.
- pending_count: always equals the popcount of pending[31:1] as of the last edge; it may be tracked incrementally but must never drift.
- Write to a non-pending register: the data is written and pending is unchanged (no underflow).
- No internal FSM beyond the per-register pending bits; there is no backpressure.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: when wr_en=1, wr_addr!=0, and rd_addrN==wr_addr in the same cycle:
  - rd_dataN = wr_data (write-through, combinational).
  - busyN = 0, unless mark_en=1 with mark_addr==wr_addr that cycle, in which case busyN = 1.
- Undefined: reads return the stored value and pending bit; the new data and cleared busy become visible the cycle after the write edge.

Test Plan:
- Reset: hold rst_n=0 for 2 edges after random writes/marks -> all rd_data=0, busy=0, pending_count=0; wr_en=1 during reset leaves regs unchanged.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xDEADBEEF; mark_addr=0 -> rd_addr1=0 gives 0, busy1=0, pending_count=0.
- Mark then write: mark r8 (count->1, busy on r8=1); 3 cycles later write r8=0x1234 -> next cycle rd_data=0x1234, busy=0, count=0.
- Same-cycle mark and write r17 with data 0xA5A5A5A5 -> regs[17]=0xA5A5A5A5, busy=1, count=1; a following write r17=0x1 -> busy=0, count=0.
- Count saturation: mark r1..r31 over consecutive cycles, then re-mark r5 -> count=31; write to unmarked-then-marked r31 twice -> count drops to 30 once, never wraps.
- Bypass: write r3=0x77 while reading rd_addr2=3 -> with REGFILE_BYPASS_EN defined, rd_data2=0x77 in the same cycle; without it, the old value, then 0x77 the next cycle.
